lsu_mem_ctrl: RTL and testbench

- Load/store initiator that sits between the CPU datapath and the word-wide data memory block (ports MemRead/MemWrite/addr/data_in/data_out).
- Converts byte/halfword/word loads and stores into word accesses; sub-word stores use read-modify-write because the memory has a single word write enable.
- Holds the CPU through a ready/valid handshake and returns sign- or zero-extended load data.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_byte_lane.sv | 34 +++
 rtl/lsu_mem_ctrl.sv | 141 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    RESP
  } state_t;

  // Size 2'b11 behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SZ_W : size;
  endfunction

  // Byte offset actually used once the low address bits are masked per size.
  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    unique case (size)
      SZ_B:    return off;
      SZ_H:    return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    unique case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    unique case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational load extract (with sign/zero extension) and sub-word store merge.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [31:0] shifted_rd;
  logic [31:0] shifted_wd;
  logic [3:0]  be;

  always_comb begin
    shifted_rd = word >> {offset, 3'b000};
    shifted_wd = wdata << {offset, 3'b000};
    be         = lane_mask(size, offset);
    rdata      = word;
    merged     = word;
    unique case (size)
      SZ_B:    rdata = {{24{~is_unsigned & shifted_rd[7]}}, shifted_rd[7:0]};
      SZ_H:    rdata = {{16{~is_unsigned & shifted_rd[15]}}, shifted_rd[15:0]};
      default: rdata = word;
    endcase
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = shifted_wd[8*i +: 8];
    end
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator to a word-wide memory; sub-word stores use read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests respond with resp_err and no access.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t      state;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        we_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [1:0]  cnt;

  logic [1:0]  req_sz;
  logic [1:0]  req_off;
  logic        misaligned;
  logic [31:0] ext_data;
  logic [31:0] merged;

  assign req_ready = (state == IDLE);
  assign req_sz    = norm_size(req_size);
  assign req_off   = align_off(req_sz, req_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = is_misaligned(req_sz, req_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // Operates directly on mem_rdata so the WAIT cycle can register the result.
  lsu_byte_lane u_lane (
    .size        (size_q),
    .is_unsigned (uns_q),
    .offset      (off_q),
    .word        (mem_rdata),
    .wdata       (wdata_q),
    .rdata       (ext_data),
    .merged      (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      size_q     <= SZ_B;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      off_q      <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            size_q   <= req_sz;
            uns_q    <= req_unsigned;
            we_q     <= req_we;
            off_q    <= req_off;
            wdata_q  <= req_wdata;
            mem_addr <= 32'(req_addr[ADDR_W-1:2]);
            if (misaligned) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else if (req_we && req_sz == SZ_W) begin
              mem_write <= 1'b1;
              mem_wdata <= req_wdata;
              state     <= WR;
            end else begin
              mem_read <= 1'b1;
              state    <= RD;
            end
          end
        end
        RD: begin
          mem_read <= 1'b0;
          cnt      <= 2'(RD_LAT - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            if (we_q) begin
              mem_wdata <= merged;
              mem_write <= 1'b1;
              state     <= WR;
            end else begin
              resp_rdata <= ext_data;
              resp_err   <= 1'b0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        WR: begin
          mem_write  <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl with a 1-cycle synchronous word memory.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [16];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          overlap = 0;
  logic [31:0] last_raddr = '0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.RD_LAT(1), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_read) begin
      mem_rdata  <= mem[mem_addr[3:0]];
      rd_cnt     <= rd_cnt + 1;
      last_raddr <= mem_addr;
    end
    if (mem_write) begin
      mem[mem_addr[3:0]] <= mem_wdata;
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
    end
    if (mem_read && mem_write) overlap <= overlap + 1;
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic err);
    int w;
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 99; rd = '0; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i; rd = resp_rdata; err = resp_err;
        break;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
  endtask

  task automatic test_word_store_load();
    int lat; logic [31:0] rd; logic err; int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, err);
    chk("sw latency", 32'(lat), 32'd2);
    chk("sw write count", 32'(wr_cnt - w0), 32'd1);
    chk("sw read count", 32'(rd_cnt - r0), 32'd0);
    chk("sw word addr", last_waddr, 32'h4);
    chk("sw mem word", mem[4], 32'hDEADBEEF);
    chk("sw resp", {rd[30:0], err}, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, err);
    chk("lw latency", 32'(lat), 32'd3);
    chk("lw data", rd, 32'hDEADBEEF);
    chk("lw read count", 32'(rd_cnt - r0), 32'd1);
  endtask

  task automatic test_byte_rmw();
    int lat; logic [31:0] rd; logic err; int r0, w0;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat, rd, err);
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, lat, rd, err);
    chk("sb latency", 32'(lat), 32'd4);
    chk("sb read count", 32'(rd_cnt - r0), 32'd1);
    chk("sb write count", 32'(wr_cnt - w0), 32'd1);
    chk("sb merged data", last_wdata, 32'h1122AA44);
    chk("sb read addr", last_raddr, 32'h4);
    chk("sb write addr", last_waddr, 32'h4);
  endtask

  task automatic test_extension();
    int lat; logic [31:0] rd; logic err;
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01, lat, rd, err);
    issue(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, lat, rd, err);
    chk("lb +2", rd, 32'hFFFFFFFF);
    issue(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, lat, rd, err);
    chk("lbu +2", rd, 32'h000000FF);
    issue(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, lat, rd, err);
    chk("lh +0", rd, 32'h00007F01);
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, lat, rd, err);
    chk("lh +2", rd, 32'hFFFF80FF);
    issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, lat, rd, err);
    chk("lhu +2", rd, 32'h000080FF);
    issue(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, lat, rd, err);
    chk("lb +1", rd, 32'h0000007F);
    issue(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, lat, rd, err);
    chk("lb +3", rd, 32'hFFFFFF80);
    issue(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, lat, rd, err);
    chk("size 11 as word", rd, 32'h80FF7F01);
  endtask

  task automatic test_half_store();
    int lat; logic [31:0] rd; logic err;
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, lat, rd, err);
    chk("sh latency", 32'(lat), 32'd4);
    chk("sh merged data", last_wdata, 32'hBEEF7F01);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, err);
    chk("sh readback", rd, 32'hBEEF7F01);
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] rd; logic err; int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat, rd, err);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("misalign latency", 32'(lat), 32'd1);
    chk("misalign err", 32'(err), 32'd1);
    chk("misalign rdata", rd, 32'd0);
    chk("misalign no access", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
`else
    chk("masked lw latency", 32'(lat), 32'd3);
    chk("masked lw err", 32'(err), 32'd0);
    chk("masked lw data", rd, 32'h1122AA44);
    chk("masked lw read addr", last_raddr, 32'h4);
    chk("masked lw access", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd1);
`endif
  endtask

  task automatic test_reset_mid_rmw();
    int lat; logic [31:0] rd; logic err; int w0;
    w0 = wr_cnt;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h5555;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid-rmw reset ready", 32'(req_ready), 32'd1);
    chk("mid-rmw reset outs", {27'd0, mem_read, mem_write, resp_valid, resp_err, 1'b0}, 32'd0);
    chk("mid-rmw reset addr", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid-rmw no write", 32'(wr_cnt - w0), 32'd0);
    chk("mid-rmw mem unchanged", mem[4], 32'h1122AA44);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, err);
    chk("mid-rmw readback", rd, 32'h1122AA44);
  endtask

  task automatic test_back_to_back();
    int r0; int n; logic [31:0] d1; logic seen;
    r0 = rd_cnt;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h20;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_addr = 32'h10;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
    chk("held first latency", 32'(n), 32'd3);
    chk("held first data", resp_rdata, 32'hBEEF7F01);
    chk("held ready in resp", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("held ready after resp", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0; d1 = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        chk("held second latency", 32'(i), 32'd3);
        d1 = resp_rdata; seen = 1'b1;
        break;
      end
    end
    chk("held second seen", 32'(seen), 32'd1);
    chk("held second data", d1, 32'h1122AA44);
    chk("held read count", 32'(rd_cnt - r0), 32'd2);
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_extension();
    test_half_store();
    test_misalign();
    test_reset_mid_rmw();
    test_back_to_back();
    chk("no read/write overlap", 32'(overlap), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
